// File: rtl/excess3_deserializer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : excess3_deserializer_pkg
// Description : Shared constants and types for the Excess-3 deserializer.
//               Digit width, valid Excess-3 code range, decode offset.
// Revision    : 1.0 - initial release
// ============================================================================
package excess3_deserializer_pkg;

    localparam int DIGIT_BITS = 4;

    // Legal Excess-3 codes are 0011 (BCD 0) through 1100 (BCD 9)
    localparam logic [DIGIT_BITS-1:0] XS3_MIN    = 4'd3;
    localparam logic [DIGIT_BITS-1:0] XS3_MAX    = 4'd12;
    localparam logic [DIGIT_BITS-1:0] XS3_OFFSET = 4'd3;

    typedef logic [DIGIT_BITS-1:0] xs3_digit_t;

endpackage : excess3_deserializer_pkg
`default_nettype wire

// File: rtl/excess3_deserializer_if.sv
`default_nettype none
// ============================================================================
// Module      : excess3_deserializer_if
// Description : Serial input strobe/data/flag and parallel digit/word
//               outputs of the Excess-3 deserializer. The bcd bundle exists
//               only when DECODE_BCD_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface excess3_deserializer_if #(
    parameter int NDIGITS = 2
);
    import excess3_deserializer_pkg::*;

    // Serial side (driven by the converter)
    logic                        en;
    logic                        s;
    logic                        v;

    // Parallel side (driven by the deserializer)
    xs3_digit_t                  digit;
    logic                        dvalid;
    logic                        derr;
    logic [DIGIT_BITS*NDIGITS-1:0] word;
    logic                        wvalid;
    logic                        werr;
    logic [1:0]                  bitidx;
`ifdef DECODE_BCD_EN
    logic [DIGIT_BITS*NDIGITS-1:0] bcd;
`endif

    // Stream source / result consumer
    modport master (
        output en, s, v,
        input  digit, dvalid, derr, word, wvalid, werr, bitidx
`ifdef DECODE_BCD_EN
        , input bcd
`endif
    );

    // Deserializer
    modport slave (
        input  en, s, v,
        output digit, dvalid, derr, word, wvalid, werr, bitidx
`ifdef DECODE_BCD_EN
        , output bcd
`endif
    );

endinterface : excess3_deserializer_if
`default_nettype wire

// File: rtl/excess3_deserializer_xs3_digit_check.sv
`default_nettype none
// ============================================================================
// Module      : xs3_digit_check
// Description : Combinational Excess-3 digit checker. Flags codes outside
//               0011..1100; with DECODE_BCD_EN also returns code - 3.
// Revision    : 1.0 - initial release
// ============================================================================
module xs3_digit_check
    import excess3_deserializer_pkg::*;
(
    input  xs3_digit_t code,
    output logic       range_err
`ifdef DECODE_BCD_EN
    ,
    output xs3_digit_t bcd
`endif
);

    // Out-of-range detection for one Excess-3 code
    always_comb begin
        range_err = (code < XS3_MIN) || (code > XS3_MAX);
    end

`ifdef DECODE_BCD_EN
    // Modulo-16 subtract; out-of-range codes are masked by the caller
    always_comb begin
        bcd = code - XS3_OFFSET;
    end
`endif

endmodule : xs3_digit_check
`default_nettype wire

// File: rtl/excess3_deserializer.sv
`default_nettype none
// ============================================================================
// Module      : excess3_deserializer
// Description : Collects a serial Excess-3 stream (LSB first, 4 bits per
//               digit) into parallel digits, validates each digit and
//               assembles NDIGITS digits into a word with a valid strobe.
//               Optional macro DECODE_BCD_EN adds a registered BCD view of
//               the word (error slots read 4'hF).
// Revision    : 1.0 - initial release
// ============================================================================
module excess3_deserializer
    import excess3_deserializer_pkg::*;
#(
    parameter int NDIGITS = 2,
    parameter int CNTW    = 3
) (
    input  wire logic             clk,
    input  wire logic             rst,
    excess3_deserializer_if.slave bus
);

    localparam int               WORD_BITS   = DIGIT_BITS * NDIGITS;
    localparam logic [CNTW-1:0]  c_last_slot = CNTW'(NDIGITS - 1);

    // Bit / digit sequencing state
    logic [1:0]           r_b;
    // Only three pending bits are ever needed: the fourth arrives on s
    logic [2:0]           r_sr;
    logic                 r_de;
    logic [CNTW-1:0]      r_d;
    logic [WORD_BITS-1:0] r_wacc;
    logic                 r_we;

    // Registered outputs
    xs3_digit_t           r_digit;
    logic                 r_dvalid;
    logic                 r_derr;
    logic [WORD_BITS-1:0] r_word;
    logic                 r_wvalid;
    logic                 r_werr;

    xs3_digit_t           w_code;
    logic                 w_range_err;
    logic                 w_derr_next;
    logic                 w_digit_done;
    logic                 w_word_done;
    logic [WORD_BITS-1:0] w_word_next;

    assign w_code       = {bus.s, r_sr};
    assign w_digit_done = bus.en && (r_b == 2'd3);
    assign w_word_done  = w_digit_done && (r_d == c_last_slot);
    assign w_derr_next  = r_de | bus.v | w_range_err;

    xs3_digit_check u_completion_check (
        .code      (w_code),
        .range_err (w_range_err)
`ifdef DECODE_BCD_EN
        ,
        .bcd       ()
`endif
    );

    // Word accumulator with the current code dropped into slot r_d
    always_comb begin
        w_word_next = r_wacc;
        for (int k = 0; k < NDIGITS; k++) begin
            if (r_d == CNTW'(k)) begin
                w_word_next[k*DIGIT_BITS +: DIGIT_BITS] = w_code;
            end
        end
    end

    // Bit shifting, digit/word completion and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_b      <= '0;
            r_sr     <= '0;
            r_de     <= 1'b0;
            r_d      <= '0;
            r_wacc   <= '0;
            r_we     <= 1'b0;
            r_digit  <= '0;
            r_dvalid <= 1'b0;
            r_derr   <= 1'b0;
            r_word   <= '0;
            r_wvalid <= 1'b0;
            r_werr   <= 1'b0;
        end else begin
            r_dvalid <= 1'b0;
            r_wvalid <= 1'b0;
            if (bus.en) begin
                if (r_b != 2'd3) begin
                    r_sr <= {bus.s, r_sr[2:1]};
                    r_de <= r_de | bus.v;
                    r_b  <= r_b + 2'd1;
                end else begin
                    r_digit  <= w_code;
                    r_dvalid <= 1'b1;
                    r_derr   <= w_derr_next;
                    r_b      <= 2'd0;
                    r_de     <= 1'b0;
                    r_wacc   <= w_word_next;
                    if (r_d == c_last_slot) begin
                        r_word   <= w_word_next;
                        r_werr   <= r_we | w_derr_next;
                        r_wvalid <= 1'b1;
                        r_d      <= '0;
                        r_we     <= 1'b0;
                    end else begin
                        r_we <= r_we | w_derr_next;
                        r_d  <= r_d + CNTW'(1);
                    end
                end
            end
        end
    end

`ifdef DECODE_BCD_EN
    // Per-slot error flags so the decoded word can mark bad digits
    logic [NDIGITS-1:0]   r_slot_err;
    logic [NDIGITS-1:0]   w_slot_err_next;
    logic [WORD_BITS-1:0] w_bcd_next;
    logic [WORD_BITS-1:0] r_bcd;

    // Current digit's error recorded in slot r_d
    always_comb begin
        w_slot_err_next = r_slot_err;
        for (int k = 0; k < NDIGITS; k++) begin
            if (r_d == CNTW'(k)) begin
                w_slot_err_next[k] = w_derr_next;
            end
        end
    end

    for (genvar g = 0; g < NDIGITS; g++) begin : g_decode
        xs3_digit_t w_slot_bcd;
        logic       w_slot_range;

        xs3_digit_check u_slot_check (
            .code      (w_word_next[g*DIGIT_BITS +: DIGIT_BITS]),
            .range_err (w_slot_range),
            .bcd       (w_slot_bcd)
        );

        // Bad slots read as 4'hF instead of a wrapped subtraction
        always_comb begin
            w_bcd_next[g*DIGIT_BITS +: DIGIT_BITS] =
                (w_slot_err_next[g] || w_slot_range) ? 4'hF : w_slot_bcd;
        end
    end

    // Slot error tracking and decoded word, updated together with word
    always_ff @(posedge clk) begin
        if (rst) begin
            r_slot_err <= '0;
            r_bcd      <= '0;
        end else if (w_digit_done) begin
            r_slot_err <= w_word_done ? '0 : w_slot_err_next;
            if (w_word_done) begin
                r_bcd <= w_bcd_next;
            end
        end
    end

    assign bus.bcd = r_bcd;
`endif

    assign bus.digit  = r_digit;
    assign bus.dvalid = r_dvalid;
    assign bus.derr   = r_derr;
    assign bus.word   = r_word;
    assign bus.wvalid = r_wvalid;
    assign bus.werr   = r_werr;
    assign bus.bitidx = r_b;

endmodule : excess3_deserializer
`default_nettype wire

// File: tb/tb_excess3_deserializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_excess3_deserializer
// Description : Directed self-checking bench for excess3_deserializer with
//               NDIGITS=2 (optionally checks bcd under DECODE_BCD_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_excess3_deserializer;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    excess3_deserializer_if #(.NDIGITS(2)) bus ();

    excess3_deserializer #(.NDIGITS(2), .CNTW(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Apply inputs for one clock, then settle just after the rising edge
    task automatic drive(input logic e, input logic sb, input logic vb);
        bus.en = e;
        bus.s  = sb;
        bus.v  = vb;
        @(posedge clk);
        #1;
    endtask

    task automatic send_digit(input logic [3:0] code, input logic [3:0] vmask);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, code[i], vmask[i]);
        end
    endtask

    logic [3:0] stream [8];

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        bus.en   = 1'b0;
        bus.s    = 1'b0;
        bus.v    = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;

        check("rst_digit",  32'(bus.digit),  32'h0);
        check("rst_dvalid", 32'(bus.dvalid), 32'h0);
        check("rst_word",   32'(bus.word),   32'h0);
        check("rst_wvalid", 32'(bus.wvalid), 32'h0);
        check("rst_bitidx", 32'(bus.bitidx), 32'h0);
        rst = 1'b0;

        // Single digit 1000
        drive(1'b1, 1'b0, 1'b0);
        check("bitidx_1", 32'(bus.bitidx), 32'h1);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        check("dvalid_early", 32'(bus.dvalid), 32'h0);
        drive(1'b1, 1'b1, 1'b0);
        check("d0_digit",  32'(bus.digit),  32'h8);
        check("d0_dvalid", 32'(bus.dvalid), 32'h1);
        check("d0_derr",   32'(bus.derr),   32'h0);
        check("d0_bitidx", 32'(bus.bitidx), 32'h0);
        check("d0_wvalid", 32'(bus.wvalid), 32'h0);

        // Second digit 0011 completes word 0x38
        send_digit(4'b0011, 4'b0000);
        check("w0_digit",  32'(bus.digit),  32'h3);
        check("w0_dvalid", 32'(bus.dvalid), 32'h1);
        check("w0_wvalid", 32'(bus.wvalid), 32'h1);
        check("w0_word",   32'(bus.word),   32'h38);
        check("w0_werr",   32'(bus.werr),   32'h0);
`ifdef DECODE_BCD_EN
        check("w0_bcd",    32'(bus.bcd),    32'h05);
`endif
        drive(1'b0, 1'b0, 1'b0);
        check("idle_dvalid", 32'(bus.dvalid), 32'h0);
        check("idle_wvalid", 32'(bus.wvalid), 32'h0);
        check("idle_word",   32'(bus.word),   32'h38);

        // Range errors: 0001 then 1101
        send_digit(4'b0001, 4'b0000);
        check("lo_derr", 32'(bus.derr), 32'h1);
        send_digit(4'b1101, 4'b0000);
        check("hi_derr",   32'(bus.derr),   32'h1);
        check("w1_wvalid", 32'(bus.wvalid), 32'h1);
        check("w1_word",   32'(bus.word),   32'hD1);
        check("w1_werr",   32'(bus.werr),   32'h1);

        // V flag on bit 2 of a valid code, then a clean digit
        send_digit(4'b0100, 4'b0100);
        check("v_derr",   32'(bus.derr),  32'h1);
        check("v_digit",  32'(bus.digit), 32'h4);
        send_digit(4'b0101, 4'b0000);
        check("clean_derr", 32'(bus.derr),  32'h0);
        check("w2_word",    32'(bus.word),  32'h54);
        check("w2_werr",    32'(bus.werr),  32'h1);

        // Clean word clears the word error
        send_digit(4'b0011, 4'b0000);
        send_digit(4'b0100, 4'b0000);
        check("w3_word", 32'(bus.word), 32'h43);
        check("w3_werr", 32'(bus.werr), 32'h0);

        // EN gaps inside digit 0110; junk on s/v while idle must be ignored
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        for (int g = 0; g < 3; g++) begin
            drive(1'b0, g[0], 1'b1);
            check("gap_dvalid", 32'(bus.dvalid), 32'h0);
            check("gap_bitidx", 32'(bus.bitidx), 32'h2);
        end
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        check("gap_digit",  32'(bus.digit),  32'h6);
        check("gap_dvalid", 32'(bus.dvalid), 32'h1);
        check("gap_derr",   32'(bus.derr),   32'h0);
        send_digit(4'b0111, 4'b0000);
        check("w4_word", 32'(bus.word), 32'h76);
        check("w4_werr", 32'(bus.werr), 32'h0);

        // Reset mid-digit after one full digit of the next word
        send_digit(4'b1001, 4'b0000);
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        check("mrst_digit",  32'(bus.digit),  32'h0);
        check("mrst_word",   32'(bus.word),   32'h0);
        check("mrst_bitidx", 32'(bus.bitidx), 32'h0);
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0);
        check("post_rst_digit",  32'(bus.digit),  32'h0);
        check("post_rst_dvalid", 32'(bus.dvalid), 32'h0);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        check("rr_digit",  32'(bus.digit),  32'hA);
        check("rr_wvalid", 32'(bus.wvalid), 32'h0);
        send_digit(4'b0101, 4'b0000);
        check("rr_wvalid2", 32'(bus.wvalid), 32'h1);
        check("rr_word",    32'(bus.word),   32'h5A);

        // Four back-to-back words with EN held high
        stream[0] = 4'h3; stream[1] = 4'h4; stream[2] = 4'h5; stream[3] = 4'h6;
        stream[4] = 4'h7; stream[5] = 4'h8; stream[6] = 4'h9; stream[7] = 4'hC;
        for (int n = 0; n < 8; n++) begin
            for (int i = 0; i < 4; i++) begin
                drive(1'b1, stream[n][i], 1'b0);
                check("st_dvalid", 32'(bus.dvalid), (i == 3) ? 32'h1 : 32'h0);
                check("st_wvalid", 32'(bus.wvalid), (i == 3 && n[0]) ? 32'h1 : 32'h0);
            end
            check("st_digit", 32'(bus.digit), 32'(stream[n]));
            if (n[0]) begin
                check("st_word", 32'(bus.word), 32'({stream[n], stream[n-1]}));
                check("st_werr", 32'(bus.werr), 32'h0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_excess3_deserializer
`default_nettype wire

// File: doc/excess3_deserializer.md
Name: excess3_deserializer

Overview:
- Downstream stage of the serial BCD-to-Excess-3 converter.
- Collects the converter's serial output S, LSB first, 4 bits per digit, into parallel Excess-3 digits.
- Validates each digit (code range and the converter's V flag) and assembles NDIGITS digits into a parallel word with a one-cycle valid strobe.
- Samples on the rising edge of CLK; the converter updates on the falling edge, so every bit is sampled mid-period.

Parameters:
- NDIGITS, 2, digits per assembled word (1..8).
- CNTW, 3, width of digit index counter; must satisfy 2^CNTW > NDIGITS.

Ports:
- CLK  in  1  system clock; all state changes on posedge.
- RST  in  1  synchronous active-high reset.
- EN  in  1  bit strobe; S and V are sampled only when EN=1.
- S  in  1  serial Excess-3 bit from converter, LSB first.
- V  in  1  converter flag; V=1 on any sampled bit marks the current digit bad.
- DIGIT  out  4  last completed Excess-3 digit.
- DVALID  out  1  one-cycle pulse: DIGIT updated.
- DERR  out  1  error for DIGIT; valid with DVALID, held until next DVALID.
- WORD  out  4*NDIGITS  assembled digits; first-received digit in bits [3:0].
- WVALID  out  1  one-cycle pulse: WORD updated.
- WERR  out  1  OR of DERR over the digits of WORD; held until next WVALID.
- BITIDX  out  2  bit position expected next (0..3).

Behaviour:
- Reset (RST=1 at posedge): all outputs, shift register, bit counter, digit counter and error accumulators go to 0. Reset has priority over EN. Reset mid-digit or mid-word discards the partial data; no DVALID/WVALID is produced for it.
- State: bit counter b (0..3), 4-bit shift register sr, sticky digit error de, digit counter d (0..NDIGITS-1), word accumulator wacc, word error we.
- EN=0: all state held; DVALID and WVALID forced 0.
- EN=1 and b<3: sr <= {S, sr[3:1]}; de <= de | V; b <= b+1.
- EN=1 and b=3 (digit completion):
  - DIGIT <= {S, sr[3:1]}; DVALID <= 1; b <= 0; de <= 0.
  - DERR <= de | V | (code < 4'd3) | (code > 4'd12), where code = {S, sr[3:1]}.
  - Same cycle: the code is written into wacc slot d, and we accumulates DERR's next value.
- Word completion (digit completion with d=NDIGITS-1):
  - WORD <= wacc with the final slot filled; WERR <= accumulated error including the final digit; WVALID <= 1.
  - d <= 0; we <= 0. Otherwise d <= d+1.
- Latency: DVALID is asserted in the cycle after the posedge that samples the 4th bit (registered output). WVALID is asserted in the same cycle as the DVALID of the last digit.
- Back-to-back digits with EN held high: no idle cycle required; DVALID may pulse every 4th cycle.
- Error handling: errored digits are still stored and counted. Errors never stall or resynchronise the stream.
- BITIDX = b, combinational from the register.

Optional Feature:
- Macro: DECODE_BCD_EN.
- Defined: adds output BCD (4*NDIGITS). Each slot = WORD slot - 3 (mod 16), registered and updated with WORD, so it is valid with WVALID. Error slots output 4'hF.
- Undefined: no BCD port and no subtractors.

Decomposition:
- Shared package holds:
  - DIGIT_BITS=4.
  - XS3_MIN=4'd3 and XS3_MAX=4'd12.
  - XS3_OFFSET=4'd3.
  - Digit typedef (4-bit logic).
- Natural sub-module: xs3_digit_check (combinational). Input 4-bit code; outputs range-error flag and, under DECODE_BCD_EN, the BCD value. Shared by the completion path and the decode path.

Test Plan:
- Digit decode: NDIGITS=2, EN=1, S bits 0,0,0,1 (code 1000), V=0 -> DIGIT=4'b1000, DVALID one cycle, DERR=0, BITIDX back to 0.
- Word assembly: S digits 1000 then 0011 (each LSB first) -> WORD=8'h38, WVALID coincident with 2nd DVALID, WERR=0. With DECODE_BCD_EN: BCD=8'h05.
- Range and V errors:
  - Digit 0001 -> DERR=1.
  - Digit 1101 -> DERR=1.
  - Valid code 0100 with V=1 on bit 2 -> DERR=1; WERR=1 for the containing word; next clean digit DERR=0.
- EN gaps: bits of 0110 with EN low for 3 cycles between bits 1 and 2 -> DIGIT=4'b0110; no DVALID during gaps; state held.
- Reset mid-digit: 2 bits sent, RST for 1 cycle, then 0,1,0,1 -> DIGIT=4'b1010, d restarts at slot 0. Outputs read 0 during and right after reset.
- Streaming: 4 words back to back, EN constantly 1 -> DVALID every 4 cycles, WVALID every 8 cycles, words match sent digits exactly.
